// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared state encodings, reset PC, and instruction-memory bounds for the fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_FETCH = 2'd1,
    FETCH_BUF   = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] IM_LO    = 32'h0000_3000;
  localparam logic [31:0] IM_HI    = 32'h0000_6FFC;

  // One fetched instruction together with its PC and fetch-error flag.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } fetch_ent_t;

  // Misaligned, or outside the instruction memory window.
  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < IM_LO) || (a > IM_HI);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/ack bus between the fetch stage and instruction memory.
// Latency: ack may come in the same cycle as req, or any number of cycles later.
// Backpressure: memory withholds ack; addr is held stable until ack arrives.
interface fetch_unit_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;

  modport master (output im_req, output im_addr, input im_ack, input im_rdata);
  modport slave  (input im_req, input im_addr, output im_ack, output im_rdata);
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// if_id_reg: IF/ID pipeline register holding pc_d, instr_d, valid_d and adel_d.
// Latency: one edge from ld to outputs.
// Backpressure: holds its contents whenever ld is low.
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ld,
  input  fetch_ent_t  d,
  output logic [31:0] pc_d,
  output logic [31:0] instr_d,
  output logic        valid_d,
  output logic        adel_d
);

  // Load on ld; once valid it stays valid, since D never takes a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_d    <= '0;
      instr_d <= '0;
      valid_d <= 1'b0;
      adel_d  <= 1'b0;
    end else if (ld) begin
      pc_d    <= d.pc;
      instr_d <= d.instr;
      valid_d <= 1'b1;
      adel_d  <= d.adel;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: F-stage PC, instruction-memory requester, one-entry skid buffer and IF/ID register.
// Latency: one edge from ack to instr_d; zero-wait memory gives one instruction per cycle.
// Backpressure: stall with ack parks the instruction in the skid buffer; fetch_busy reports wait states.
// Optional feature: define FETCH_ADEL_CHECK_EN to turn bad fetch addresses into a NOP with adel_d=1.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       npc,
  input  logic              stall,
  fetch_unit_if.master      im,
  output logic              fetch_busy,
  output logic [31:0]       pc_f,
  output logic [31:0]       pc_d,
  output logic [31:0]       instr_d,
  output logic              valid_d,
  output logic              adel_d
);

`ifdef FETCH_ADEL_CHECK_EN
  localparam bit ADEL_EN = 1'b1;
`else
  localparam bit ADEL_EN = 1'b0;
`endif

  fetch_state_t state;
  logic [31:0]  pc_q;
  logic         req_q;
  fetch_ent_t   skid;

  logic         adel_f;
  logic         ack_eff;
  logic         ld_d;
  fetch_ent_t   f_ent;
  fetch_ent_t   d_in;

  // A bad address completes immediately as a NOP without touching memory.
  assign adel_f  = ADEL_EN && addr_err(pc_q);
  assign ack_eff = im.im_ack || adel_f;

  assign f_ent.pc    = pc_q;
  assign f_ent.instr = adel_f ? 32'h0000_0000 : im.im_rdata;
  assign f_ent.adel  = adel_f;

  assign ld_d = !stall && (((state == FETCH_FETCH) && ack_eff) || (state == FETCH_BUF));
  assign d_in = (state == FETCH_BUF) ? skid : f_ent;

  assign fetch_busy = (state == FETCH_IDLE) || ((state == FETCH_FETCH) && !ack_eff);
  assign im.im_req  = req_q;
  assign im.im_addr = pc_q;
  assign pc_f       = pc_q;

  // Fetch FSM: owns pc_f, the skid buffer and the registered memory request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH_IDLE;
      pc_q  <= RESET_PC;
      req_q <= 1'b0;
      skid  <= '0;
    end else begin
      case (state)
        FETCH_IDLE: begin
          state <= FETCH_FETCH;
          req_q <= !(ADEL_EN && addr_err(pc_q));
        end
        FETCH_FETCH: begin
          if (ack_eff) begin
            if (stall) begin
              skid  <= f_ent;
              state <= FETCH_BUF;
              req_q <= 1'b0;
            end else begin
              pc_q  <= npc;
              req_q <= !(ADEL_EN && addr_err(npc));
            end
          end
        end
        FETCH_BUF: begin
          if (!stall) begin
            state <= FETCH_FETCH;
            pc_q  <= npc;
            req_q <= !(ADEL_EN && addr_err(npc));
          end
        end
        default: begin
          state <= FETCH_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .ld      (ld_d),
    .d       (d_in),
    .pc_d    (pc_d),
    .instr_d (instr_d),
    .valid_d (valid_d),
    .adel_d  (adel_d)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// Inputs change on the falling edge; outputs are checked on the falling edge (registered) or 1ns later (combinational).
// Memory ack timing and npc are scripted step by step.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] npc;
  logic        stall;
  logic        fetch_busy;
  logic [31:0] pc_f, pc_d, instr_d;
  logic        valid_d, adel_d;

  int tests = 0;
  int fails = 0;

  fetch_unit_if imb ();

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .npc        (npc),
    .stall      (stall),
    .im         (imb),
    .fetch_busy (fetch_busy),
    .pc_f       (pc_f),
    .pc_d       (pc_d),
    .instr_d    (instr_d),
    .valid_d    (valid_d),
    .adel_d     (adel_d)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [31:0] a);
    return 32'h2400_0000 | {16'h0000, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mem(input logic ack, input logic [31:0] rdata);
    imb.im_ack   = ack;
    imb.im_rdata = rdata;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; npc = 32'h3004; mem(1'b0, 32'h0);

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_pc_f", pc_f, 32'h3000);
    chk("rst_pc_d", pc_d, 32'h0);
    chk("rst_instr_d", instr_d, 32'h0);
    chk("rst_valid_d", {31'b0, valid_d}, 32'h0);
    chk("rst_adel_d", {31'b0, adel_d}, 32'h0);
    chk("rst_im_req", {31'b0, imb.im_req}, 32'h0);
    chk("rst_busy", {31'b0, fetch_busy}, 32'h1);
    reset = 1'b0;
    #1 chk("idle_req", {31'b0, imb.im_req}, 32'h0);

    // Zero-wait memory: one instruction per cycle
    @(negedge clk);
    chk("zw_req_rise", {31'b0, imb.im_req}, 32'h1);
    chk("zw_addr0", imb.im_addr, 32'h3000);
    mem(1'b1, ins(32'h3000)); npc = 32'h3004;
    #1 chk("zw_busy0", {31'b0, fetch_busy}, 32'h0);
    @(negedge clk);
    chk("zw_pc_d0", pc_d, 32'h3000);
    chk("zw_instr0", instr_d, ins(32'h3000));
    chk("zw_valid", {31'b0, valid_d}, 32'h1);
    chk("zw_addr1", imb.im_addr, 32'h3004);
    mem(1'b1, ins(32'h3004)); npc = 32'h3008;
    @(negedge clk);
    chk("zw_pc_d1", pc_d, 32'h3004);
    mem(1'b1, ins(32'h3008)); npc = 32'h300C;
    @(negedge clk);
    chk("zw_pc_d2", pc_d, 32'h3008);
    chk("zw_pc_f3", pc_f, 32'h300C);

    // Three-cycle memory: two busy cycles, address stable, loaded once
    mem(1'b0, 32'hDEAD_BEEF); npc = 32'h3010;
    #1 chk("slow_busy_a", {31'b0, fetch_busy}, 32'h1);
    @(negedge clk);
    chk("slow_addr", imb.im_addr, 32'h300C);
    chk("slow_req", {31'b0, imb.im_req}, 32'h1);
    chk("slow_pc_d_hold", pc_d, 32'h3008);
    #1 chk("slow_busy_b", {31'b0, fetch_busy}, 32'h1);
    @(negedge clk);
    chk("slow_addr2", imb.im_addr, 32'h300C);
    mem(1'b1, ins(32'h300C));
    #1 chk("slow_busy_c", {31'b0, fetch_busy}, 32'h0);
    @(negedge clk);
    chk("slow_pc_d", pc_d, 32'h300C);
    chk("slow_instr", instr_d, ins(32'h300C));
    chk("slow_pc_f", pc_f, 32'h3010);

    // Fresh start for the skid-buffer scenario
    reset = 1'b1; mem(1'b0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mem(1'b1, ins(32'h3000)); npc = 32'h3004;
    @(negedge clk);
    chk("buf_pc_d0", pc_d, 32'h3000);
    mem(1'b1, 32'h2408_0001); stall = 1'b1; npc = 32'h3008;
    @(negedge clk);
    chk("buf_req_low", {31'b0, imb.im_req}, 32'h0);
    chk("buf_pc_d_hold", pc_d, 32'h3000);
    chk("buf_pc_f_hold", pc_f, 32'h3004);
    mem(1'b1, 32'hDEAD_BEEF);
    #1 chk("buf_busy", {31'b0, fetch_busy}, 32'h0);
    @(negedge clk);
    chk("buf_pc_d_hold2", pc_d, 32'h3000);
    stall = 1'b0;
    @(negedge clk);
    chk("buf_instr", instr_d, 32'h2408_0001);
    chk("buf_pc_d", pc_d, 32'h3004);
    chk("buf_pc_f", pc_f, 32'h3008);
    chk("buf_req_back", {31'b0, imb.im_req}, 32'h1);

    // Enter BUF again, then reset asynchronously in the middle of a cycle
    mem(1'b1, ins(32'h3008)); stall = 1'b1;
    @(negedge clk);
    chk("buf2_req_low", {31'b0, imb.im_req}, 32'h0);
    #2 reset = 1'b1;
    #1;
    chk("arst_pc_f", pc_f, 32'h3000);
    chk("arst_pc_d", pc_d, 32'h0);
    chk("arst_instr_d", instr_d, 32'h0);
    chk("arst_valid", {31'b0, valid_d}, 32'h0);
    chk("arst_req", {31'b0, imb.im_req}, 32'h0);
    chk("arst_busy", {31'b0, fetch_busy}, 32'h1);
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; mem(1'b0, 32'h0);
    @(negedge clk);
    chk("arst_addr", imb.im_addr, 32'h3000);
    chk("arst_pc_d_clear", pc_d, 32'h0);
    mem(1'b1, ins(32'h3000)); npc = 32'h3004;
    @(negedge clk);
    chk("arst_first_pc_d", pc_d, 32'h3000);
    chk("arst_first_instr", instr_d, ins(32'h3000));

    // Branch at 3000 in D; delay slot at 3004 waits two cycles; target 3040
    mem(1'b0, 32'h0); npc = 32'h3040;
    @(negedge clk);
    chk("br_hold_a", pc_d, 32'h3000);
    chk("br_slot_addr", imb.im_addr, 32'h3004);
    @(negedge clk);
    chk("br_hold_b", pc_d, 32'h3000);
    mem(1'b1, ins(32'h3004));
    @(negedge clk);
    chk("br_slot_pc_d", pc_d, 32'h3004);
    chk("br_target_addr", imb.im_addr, 32'h3040);

    // Misaligned fetch address
    mem(1'b1, ins(32'h3040)); npc = 32'h3002;
    @(negedge clk);
    chk("adel_pc_f", pc_f, 32'h3002);
`ifdef FETCH_ADEL_CHECK_EN
    chk("adel_no_req", {31'b0, imb.im_req}, 32'h0);
    mem(1'b0, 32'hDEAD_BEEF); npc = 32'h3044;
    @(negedge clk);
    chk("adel_pc_d", pc_d, 32'h3002);
    chk("adel_instr", instr_d, 32'h0);
    chk("adel_flag", {31'b0, adel_d}, 32'h1);
`else
    chk("adel_req", {31'b0, imb.im_req}, 32'h1);
    chk("adel_addr", imb.im_addr, 32'h3002);
    mem(1'b1, ins(32'h3002)); npc = 32'h3044;
    @(negedge clk);
    chk("adel_pc_d", pc_d, 32'h3002);
    chk("adel_instr", instr_d, ins(32'h3002));
    chk("adel_flag", {31'b0, adel_d}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
